// File: rtl/spi_rd_pkg.sv
// Shared types and constants for the SPI read-byte packer.
package spi_rd_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width of a lane index for a word of n bytes (at least one bit).
    function automatic int lane_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_rd_packer.sv
// Packs the SPI master's 8-bit read stream into OUT_BYTES-wide words
// with keep/last flags, under a start/abort command interface.
// Build option: define SPI_RD_BSWAP_EN for big-endian lane mapping
// (first flash byte in the MSB, keep bit-reversed to match).
module spi_rd_packer
    import spi_rd_pkg::*;
#(
    parameter int OUT_BYTES = 4,
    parameter int LEN_W     = 24
) (
    input  logic                        rd_clk,
    input  logic                        rd_rst_n,
    input  logic                        cmd_start,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic                        cmd_abort,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_vld,
    input  logic [BYTE_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        out_vld,
    output logic [BYTE_W*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]        out_keep,
    output logic                        out_last,
    input  logic                        out_ready
);

    localparam int                WORD_W    = BYTE_W * OUT_BYTES;
    localparam int                LANE_W    = lane_w(OUT_BYTES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(OUT_BYTES - 1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                out_vld_q, out_vld_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [OUT_BYTES-1:0] out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;

    logic                completes;
    logic                accept;
    logic [WORD_W-1:0]   merged;
    logic [OUT_BYTES-1:0] keep_new;

    // Physical byte position of logical lane l inside the word.
    function automatic int phys_lane(input logic [LANE_W-1:0] l);
`ifdef SPI_RD_BSWAP_EN
        return OUT_BYTES - 1 - int'(l);
`else
        return int'(l);
`endif
    endfunction

    assign completes = (lane_q == LAST_LANE) || (remaining_q == LEN_W'(1));
    // Ready is combinational on out_ready so a pending word can drain in
    // the same cycle the next one is loaded, sustaining one byte per clock.
    assign in_ready  = (state_q == PACK) && (!completes || !out_vld_q || out_ready);
    assign accept    = in_vld && in_ready;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

    // Accumulator with the incoming byte merged in, and keep mask for lanes [lane:0].
    always_comb begin
        merged   = acc_q;
        keep_new = '0;
        merged[phys_lane(lane_q)*BYTE_W +: BYTE_W] = in_data;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (i <= int'(lane_q)) keep_new[phys_lane(LANE_W'(i))] = 1'b1;
        end
    end

    // Next-state and output-register logic; abort overrides everything while busy.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        out_vld_d   = out_vld_q && !out_ready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (state_q != IDLE && cmd_abort) begin
            state_d     = IDLE;
            remaining_d = '0;
            lane_d      = '0;
            acc_d       = '0;
            out_vld_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        if (cmd_len != '0) begin
                            state_d     = PACK;
                            remaining_d = cmd_len;
                            lane_d      = '0;
                            acc_d       = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                PACK: begin
                    if (accept) begin
                        if (remaining_q != '0) remaining_d = remaining_q - LEN_W'(1);
                        if (completes) begin
                            out_vld_d  = 1'b1;
                            out_data_d = merged;
                            out_keep_d = keep_new;
                            out_last_d = (remaining_q == LEN_W'(1));
                            acc_d      = '0;
                            lane_d     = '0;
                            if (remaining_q == LEN_W'(1)) state_d = DRAIN;
                        end else begin
                            acc_d  = merged;
                            lane_d = lane_q + LANE_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_vld_q && out_ready) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lane_q      <= '0;
            acc_q       <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_rd_packer.sv
// Scoreboard bench for spi_rd_packer (OUT_BYTES=4, LEN_W=24); follows
// SPI_RD_BSWAP_EN for the expected lane mapping.
module tb_spi_rd_packer;

    localparam int OB = 4;
    localparam int LW = 24;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_abort = 1'b0;
    logic          busy, done;
    logic          in_vld = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          out_vld;
    logic [8*OB-1:0] out_data;
    logic [OB-1:0] out_keep;
    logic          out_last;
    logic          out_ready = 1'b1;

    spi_rd_packer #(.OUT_BYTES(OB), .LEN_W(LW)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .busy(busy), .done(done),
        .in_vld(in_vld), .in_data(in_data), .in_ready(in_ready),
        .out_vld(out_vld), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected word written little-endian; reordered when big-endian mapping is built.
    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
`ifdef SPI_RD_BSWAP_EN
        e.d = {d[7:0], d[15:8], d[23:16], d[31:24]};
        e.k = {k[0], k[1], k[2], k[3]};
`else
        e.d = d;
        e.k = k;
`endif
        e.l = l;
        return e;
    endfunction

    // Monitor: pop and compare on every output handshake; count done pulses.
    always @(negedge rd_clk) begin
        exp_t e;
        if (rd_rst_n && done) done_cnt++;
        if (rd_rst_n && out_vld && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got 0x%0h expected no word", out_data);
            end else begin
                e = sb.pop_front();
                check("word_data", 64'(out_data), 64'(e.d));
                check("word_keep", 64'(out_keep), 64'(e.k));
                check("word_last", 64'(out_last), 64'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic start(input logic [LW-1:0] len);
        cmd_len   = len;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Offer n consecutive bytes starting at 'first'; cyc returns clocks used.
    task automatic send_bytes(input logic [7:0] first, input int n, output int cyc);
        logic hs;
        int   guard;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            in_vld  = 1'b1;
            in_data = first + 8'(i);
            guard   = 0;
            forever begin
                @(negedge rd_clk);
                hs = in_ready;
                tick();
                cyc++;
                if (hs) break;
                guard++;
                if (guard > 200) break;
            end
            if (!hs) begin
                checks++;
                $display("FAIL send_timeout: got no in_ready expected acceptance of byte %0d", i);
                break;
            end
            acc_cnt++;
        end
        in_vld = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("done_latency", 64'(cyc), 64'(exp_cyc));
        tick();
        check("done_pulse_len", 64'(done), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   cyc;
        int   dc;
        logic [31:0] ref_d;
        logic stable;

        // Reset state
        repeat (3) @(posedge rd_clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out", {out_vld, out_last, out_keep, out_data}, 0);
        rd_rst_n = 1'b1;
        tick();

        // Aligned transfer at one byte per clock
        sb.push_back(mk(32'h04030201, 4'hF, 1'b0));
        sb.push_back(mk(32'h08070605, 4'hF, 1'b1));
        start(8);
        check("busy_after_start", 64'(busy), 1);
        send_bytes(8'h01, 8, cyc);
        check("aligned_rate", 64'(cyc), 8);
        check("done_not_early", 64'(done), 0);
        wait_done(1);

        // Partial last word
        sb.push_back(mk(32'hA3A2A1A0, 4'hF, 1'b0));
        sb.push_back(mk(32'h0000A5A4, 4'h3, 1'b1));
        start(6);
        send_bytes(8'hA0, 6, cyc);
        wait_done(1);

        // Backpressure on the first word
        out_ready = 1'b0;
        acc_cnt   = 0;
        sb.push_back(mk(32'h14131211, 4'hF, 1'b0));
        sb.push_back(mk(32'h18171615, 4'hF, 1'b1));
        start(8);
        fork
            send_bytes(8'h11, 8, cyc);
            begin
                dc = 0;
                while (!out_vld && dc < 50) begin tick(); dc++; end
                ref_d  = out_data;
                stable = 1'b1;
                repeat (10) begin
                    tick();
                    if (out_data !== ref_d || !out_vld) stable = 1'b0;
                end
                check("bp_word", 64'(ref_d), 64'(mk(32'h14131211, 4'hF, 1'b0).d));
                check("bp_stable", 64'(stable), 1);
                check("bp_in_ready_low", 64'(in_ready), 0);
                check("bp_bytes_held", 64'(acc_cnt), 7);
                out_ready = 1'b1;
            end
        join
        check("bp_bytes_all", 64'(acc_cnt), 8);
        wait_done(1);

        // Zero length
        start(0);
        check("zero_done", 64'(done), 1);
        check("zero_busy", 64'(busy), 0);
        check("zero_out_vld", 64'(out_vld), 0);
        tick();
        check("zero_done_once", 64'(done), 0);

        // Start while busy is ignored
        sb.push_back(mk(32'h24232221, 4'hF, 1'b0));
        sb.push_back(mk(32'h28272625, 4'hF, 1'b1));
        start(8);
        send_bytes(8'h21, 2, cyc);
        start(4);
        send_bytes(8'h23, 6, cyc);
        wait_done(1);

        // Abort after five bytes, then a clean transfer from lane 0
        sb.push_back(mk(32'h34333231, 4'hF, 1'b0));
        start(16);
        send_bytes(8'h31, 5, cyc);
        dc = done_cnt;
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("abort_busy", 64'(busy), 0);
        check("abort_out_vld", 64'(out_vld), 0);
        repeat (3) tick();
        check("abort_no_done", 64'(done_cnt), 64'(dc));
        sb.push_back(mk(32'h43424140, 4'hF, 1'b1));
        start(4);
        send_bytes(8'h40, 4, cyc);
        wait_done(1);

        // Asynchronous reset mid-transfer
        start(8);
        send_bytes(8'h51, 2, cyc);
        #2 rd_rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 0);
        check("arst_in_ready", 64'(in_ready), 0);
        tick();
        rd_rst_n = 1'b1;
        tick();
        sb.push_back(mk(32'h00626160, 4'h7, 1'b1));
        start(3);
        send_bytes(8'h60, 3, cyc);
        wait_done(1);

`ifdef SPI_RD_BSWAP_EN
        // Big-endian mapping with a partial last word
        sb.push_back('{d: 32'h01020304, k: 4'hF, l: 1'b0});
        sb.push_back('{d: 32'h05060000, k: 4'hC, l: 1'b1});
        start(6);
        send_bytes(8'h01, 6, cyc);
        wait_done(1);
`endif

        repeat (2) tick();
        check("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_rd_packer.md
Name: spi_rd_packer

Overview:
- Sits directly downstream of the SPI master read port in the rd_clk domain.
- Consumes the 8-bit flash read byte stream, which uses a valid/ready handshake, and packs bytes into OUT_BYTES-wide words.
- Drives a valid/ready word stream with byte-keep and last flags.
- A command interface sets the expected byte count per transfer and reports busy/done.

Parameters:
- OUT_BYTES, 4, bytes per output word (power of two, 2..8).
- LEN_W, 24, width of the byte-length field; matches the master's req_len.

Ports:
- rd_clk  input  1  clock, read domain.
- rd_rst_n  input  1  reset, asynchronous, active-low.
- cmd_start  input  1  one-cycle pulse; latches cmd_len and begins a transfer.
- cmd_len  input  LEN_W  transfer length in bytes.
- cmd_abort  input  1  one-cycle pulse; cancels the current transfer.
- busy  output  1  high from the cycle after an accepted cmd_start until return to IDLE.
- done  output  1  one-cycle pulse when a transfer completes normally.
- in_vld  input  1  read byte valid (from master rd_vld).
- in_data  input  8  read byte (from master rd_data).
- in_ready  output  1  byte accepted when in_vld && in_ready (to master rd_ready).
- out_vld  output  1  output word valid.
- out_data  output  8*OUT_BYTES  packed word.
- out_keep  output  OUT_BYTES  per-lane valid bytes.
- out_last  output  1  final word of the transfer.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_vld=0, out_data=0, out_keep=0, out_last=0. Internal: state=IDLE, remaining=0, lane=0, accumulator=0.
- States:
  - IDLE: on cmd_start with cmd_len!=0, latch remaining=cmd_len, set lane=0, go to PACK. On cmd_start with cmd_len==0, pulse done next cycle and stay in IDLE; no output word.
  - PACK: accept bytes.
    - Each accepted byte is written to accumulator lane `lane`, then lane++ and remaining--.
    - A word completes when lane==OUT_BYTES-1 or remaining==1.
  - DRAIN: the last word is in the output register, waiting for out_ready.
  - DONE: single cycle; pulse done, then return to IDLE.
- in_ready = (state==PACK) && (!completes_word || !out_vld || out_ready). This is combinational on out_ready, giving a sustained rate of 1 byte/clk.
- Word completion, on the same cycle as the completing byte handshake:
  - Load the output register: out_data is the accumulator with the new byte merged; unfilled lanes are 0.
  - out_keep has bits [lane:0] set.
  - out_last = (remaining==1).
  - Set out_vld; clear the accumulator; lane=0.
  - If it is the last word, go to DRAIN; otherwise stay in PACK.
- out_vld holds with stable data until out_vld && out_ready, then clears. The clear and a new load in the same cycle give a back-to-back word.
- DRAIN → DONE on the out_ready handshake; done is asserted in the cycle after that handshake.
- Lane mapping (default): byte k of a word is at out_data[8k+7:8k], little-endian; the first flash byte is in the LSB.
- Arithmetic: remaining is LEN_W bits and never decrements below 0. lane is clog2(OUT_BYTES) bits and wraps to 0 at word completion.
- Boundaries:
  - cmd_start while busy: ignored.
  - cmd_abort in any non-IDLE state: next cycle state=IDLE, out_vld=0, accumulator cleared, done not pulsed. A simultaneous byte handshake is discarded.
  - cmd_abort and cmd_start in the same cycle while IDLE: start wins. While busy: abort wins and start is ignored.
  - in_vld while IDLE or DRAIN: in_ready=0, no acceptance.
  - Async reset mid-transfer: everything returns to reset values immediately.

Optional Feature:
- Macro: SPI_RD_BSWAP_EN.
- Defined: lane mapping is big-endian. Byte k goes to out_data[8*(OUT_BYTES-1-k)+7 : 8*(OUT_BYTES-1-k)], and out_keep is bit-reversed to match, so a partial word fills from the MSB.
- Undefined: little-endian mapping as above.

Decomposition:
- Package spi_rd_pkg holds:
  - the state enum {IDLE, PACK, DRAIN, DONE};
  - the BYTE_W=8 constant;
  - the lane index width function.
- Single module; no sub-module. The output register is small enough to stay inline.

Test Plan:
- Aligned transfer: cmd_len=8, bytes 0x01..0x08, out_ready=1 → two words, 0x04030201 keep=F and 0x08070605 keep=F last=1; done 1 cycle after the second handshake; 1 byte/clk.
- Partial last word: cmd_len=6, bytes 0xA0..0xA5 → 0xA3A2A1A0 keep=F, then 0x0000A5A4 keep=3 last=1.
- Backpressure: cmd_len=8 with out_ready=0 for 10 cycles after the first word → in_ready drops on the 8th byte; out_data stays stable; no byte lost after release.
- Zero length and busy start: cmd_len=0 → done pulse, no out_vld. cmd_start during a transfer with cmd_len=4 → ignored; original count kept.
- Abort: cmd_len=16, abort after 5 bytes → out_vld=0 and busy=0 next cycle, no done. A following cmd_len=4 transfer packs correctly from lane 0.
- SPI_RD_BSWAP_EN defined: cmd_len=6, bytes 0x01..0x06 → 0x01020304 keep=F, then 0x05060000 keep=C last=1.
